rll_key_sequencer: RTL and testbench
====================================

# rll_key_sequencer

Controller that sequences one RLL-locked combinational benchmark core (32 inputs, 32 outputs, 32 key inputs). It loads the 32-bit unlock key serially into a held key register that drives the core's key inputs. It then runs evaluation transactions: apply a 32-bit input pattern, wait a programmable settle time, capture the 32-bit core response. It sits between the key-delivery/test-harness logic and the locked core; the core itself stays purely combinational.

## Interface
- KEY_W, 32, key width; equals core key-input count
- DATA_W, 32, core input/output width
- SETTLE, 2, cycles from pattern drive to response capture; must be ≥1, elaboration assertion on 0
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- key_valid  in  1  serial key bit valid
- key_bit  in  1  key bit, LSB first
- key_ready  out  1  key bit accepted when key_valid&key_ready
- key_clear  in  1  zeroise key and abort any transaction
- in_valid / in_ready  in/out  1  pattern handshake
- in_data  in  DATA_W  pattern
- out_valid / out_ready  out/in  1  response handshake
- out_data  out  DATA_W  captured response
- core_in  out  DATA_W  registered drive to core data inputs (n1..n32)
- core_key  out  KEY_W  registered drive to core key inputs
- core_out  in  DATA_W  core outputs
- keyed  out  1  full key committed
- eval_cnt  out  16  completed response handshakes

## Operation
- States: UNKEYED, LOAD, IDLE, SETTLE, HOLD.
- Reset: state UNKEYED; all outputs 0 (core_key, core_in, out_data, eval_cnt, keyed, in_ready, out_valid), except key_ready=1.
- UNKEYED/LOAD: key_ready=1, in_ready=0.
  - Each accepted bit shifts in at the MSB of the shift register; bit counter increments.
  - First accepted bit moves UNKEYED→LOAD.
  - On the KEY_W-th accepted bit: core_key ← {key_bit, shift[KEY_W-1:1]}, keyed=1, counter→0, state→IDLE. First bit sent lands in core_key[0].
  - key_valid low stalls loading with no timeout.
- IDLE: in_ready=1, key_ready=0. Accept → core_in←in_data, settle counter←SETTLE-1, state→SETTLE.
- SETTLE: in_ready=0. Counter decrements. At 0: out_data←core_out, out_valid=1, state→HOLD.
- HOLD: out_valid and out_data stay stable until out_ready. On handshake: eval_cnt+1 (wraps 0xFFFF→0), out_valid=0, state→IDLE. in_ready=0 throughout HOLD; transactions never overlap.
- core_in keeps the last pattern after a transaction. core_key changes only on commit, key_clear or rst.
- key_clear (any state, priority over every handshake in the same cycle):
  - core_key, shift register and bit counter → 0; keyed=0; out_valid=0; pending response discarded; state→UNKEYED.
  - core_in and eval_cnt are kept.
  - A key_bit presented in the same cycle is not accepted.
- Rekeying requires key_clear; key bits presented in IDLE/SETTLE/HOLD are ignored (key_ready=0).
- rst mid-load or mid-transaction → full reset state; a partial key is never committed.

## Timing
- Key load: KEY_W accepted bits minimum. keyed rises the cycle after the edge that accepts the last bit.
- Evaluation: pattern accepted at edge t. core_in is valid after t. Capture happens at edge t+SETTLE, so out_valid is high from cycle t+SETTLE.
- Minimum pattern-to-pattern spacing: SETTLE+2 cycles with out_ready held high.
- All outputs registered; no combinational path from any input to any output. in_ready, key_ready and out_valid are decoded from registered state.

## Structure
- Package rll_ctrl_pkg: state enum, KEY_W/DATA_W default constants, eval_cnt width constant.
- Sub-module rll_key_shifter: serial shift register, $clog2(KEY_W)-bit counter and commit pulse; cleared by rst or key_clear.
- Top holds the FSM, settle counter, core_in/out_data registers and eval_cnt.

## Test plan
- Key load: after reset, send 32'hA5C3_0F96 LSB first with 3 random key_valid gaps → core_key=32'hA5C3_0F96, keyed=1 one cycle after the 32nd bit, key_ready=0.
- Evaluation: SETTLE=2, core model returns core_in^core_key, in_data=32'h0000_FFFF → out_valid at t+2, out_data=32'hA5C3_F069, eval_cnt=1 after handshake.
- Backpressure: hold out_ready=0 for 10 cycles → out_data stable, in_ready=0, in_valid ignored; release → IDLE next cycle.
- key_clear mid-load (after 17 bits) and in HOLD → core_key=0, keyed=0, out_valid=0, state UNKEYED. A fresh 32-bit load then commits correctly.
- Counter wrap: preload eval_cnt near the limit (or run 65536 transactions) → 0xFFFF→0x0000, with no effect on handshakes.
- Reset mid-SETTLE → all outputs at reset values next cycle; no spurious out_valid.

Source files
------------

// File: rtl/rll_ctrl_pkg.sv
// Shared types and defaults for the RLL key sequencer: FSM state encoding,
// default widths and a counter-width helper.
package rll_ctrl_pkg;

   localparam int KEY_W_DEF  = 32;
   localparam int DATA_W_DEF = 32;
   localparam int EVAL_W     = 16;

   typedef enum logic [2:0] {
      ST_UNKEYED,
      ST_LOAD,
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } state_t;

   // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rll_key_shifter.sv
// Serial key shifter: bits enter LSB-first at the top and drift down, so the first
// bit sent ends up in bit 0 of the committed key.
module rll_key_shifter
   import rll_ctrl_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic             commit,
   output logic [KEY_W-1:0] key_next
);

   localparam int CW = cnt_w(KEY_W);

   // Only KEY_W-1 bits are stored; the final bit is taken straight from bit_in at commit.
   logic [KEY_W-2:0] shift;
   logic [CW-1:0]    cnt;

   assign key_next = {bit_in, shift};
   assign commit   = shift_en && (cnt == CW'(KEY_W - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         shift <= '0;
         cnt   <= '0;
      end else if (shift_en) begin
         shift <= key_next[KEY_W-1:1];
         cnt   <= commit ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rll_key_sequencer.sv
// Sequencer for an RLL-locked combinational core: serial key load into a held key
// register, then one-at-a-time drive/settle/capture evaluation transactions.
module rll_key_sequencer
   import rll_ctrl_pkg::*;
#(
   parameter int KEY_W  = KEY_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic              key_bit,
   output logic              key_ready,
   input  logic              key_clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] core_in,
   output logic [KEY_W-1:0]  core_key,
   input  logic [DATA_W-1:0] core_out,
   output logic              keyed,
   output logic [EVAL_W-1:0] eval_cnt
);

   localparam int SW = cnt_w(SETTLE);

   generate
      if (SETTLE < 1) begin : g_bad_settle
         $fatal(1, "rll_key_sequencer: SETTLE must be at least 1");
      end
   endgenerate

   state_t           state;
   logic [SW-1:0]    settle_cnt;
   logic             key_acc;
   logic             commit;
   logic [KEY_W-1:0] key_next;

   // key_clear wins over a key bit presented in the same cycle.
   assign key_acc = key_valid && key_ready && !key_clear;

   rll_key_shifter #(.KEY_W(KEY_W)) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .clear    (key_clear),
      .shift_en (key_acc),
      .bit_in   (key_bit),
      .commit   (commit),
      .key_next (key_next)
   );

   // Handshake flags are registered alongside the state so no input reaches an output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_UNKEYED;
         key_ready  <= 1'b1;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         keyed      <= 1'b0;
         core_key   <= '0;
         core_in    <= '0;
         out_data   <= '0;
         eval_cnt   <= '0;
         settle_cnt <= '0;
      end else if (key_clear) begin
         state     <= ST_UNKEYED;
         key_ready <= 1'b1;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         keyed     <= 1'b0;
         core_key  <= '0;
      end else begin
         case (state)
            ST_UNKEYED, ST_LOAD: begin
               if (key_acc) begin
                  if (commit) begin
                     core_key  <= key_next;
                     keyed     <= 1'b1;
                     key_ready <= 1'b0;
                     in_ready  <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  core_in    <= in_data;
                  settle_cnt <= SW'(SETTLE - 1);
                  in_ready   <= 1'b0;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  out_data  <= core_out;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  eval_cnt  <= eval_cnt + 1'b1;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_UNKEYED;
               key_ready <= 1'b1;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               keyed     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rll_key_sequencer.sv
// Directed/randomized bench for rll_key_sequencer with an XOR core model and a
// transaction-level reference (expected key, expected response, completion count).
module tb_rll_key_sequencer;
   import rll_ctrl_pkg::*;

   localparam int KW = 32;
   localparam int DW = 32;
   localparam int ST = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          key_valid, key_bit, key_clear;
   logic          key_ready;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_data, core_in, core_out;
   logic [KW-1:0] core_key;
   logic          keyed;
   logic [15:0]   eval_cnt;

   int            passed = 0;
   int            total  = 0;
   logic [31:0]   m_key;
   logic [15:0]   m_cnt;

   always #5 clk = ~clk;

   // Locked-core stand-in: response depends on both the pattern and the key.
   assign core_out = core_in ^ core_key;

   rll_key_sequencer #(.KEY_W(KW), .DATA_W(DW), .SETTLE(ST)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_bit   (key_bit),
      .key_ready (key_ready),
      .key_clear (key_clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .core_in   (core_in),
      .core_key  (core_key),
      .core_out  (core_out),
      .keyed     (keyed),
      .eval_cnt  (eval_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, want);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_core_key"}, core_key, 0);
      chk({tag, "_core_in"}, core_in, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_eval_cnt"}, {16'h0, eval_cnt}, 0);
      chk({tag, "_keyed"}, {31'h0, keyed}, 0);
      chk({tag, "_in_ready"}, {31'h0, in_ready}, 0);
      chk({tag, "_out_valid"}, {31'h0, out_valid}, 0);
      chk({tag, "_key_ready"}, {31'h0, key_ready}, 1);
   endtask

   function automatic logic [31:0] rand_gaps(input int n);
      logic [31:0] g;
      g = '0;
      while ($countones(g) < n) g[$urandom_range(31, 0)] = 1'b1;
      return g;
   endfunction

   // Present nbits of k LSB first, idling one cycle before every bit flagged in gaps.
   task automatic send_key(input logic [31:0] k, input int nbits, input logic [31:0] gaps);
      for (int i = 0; i < nbits; i++) begin
         if (gaps[i]) begin
            key_valid = 1'b0;
            @(negedge clk);
         end
         if (i == KW - 1) chk("keyed_before_last", {31'h0, keyed}, 0);
         key_valid = 1'b1;
         key_bit   = k[i];
         @(negedge clk);
      end
      key_valid = 1'b0;
   endtask

   task automatic check_keyed(input logic [31:0] k);
      m_key = k;
      chk("core_key", core_key, m_key);
      chk("keyed", {31'h0, keyed}, 1);
      chk("key_ready_after", {31'h0, key_ready}, 0);
      chk("in_ready_after_key", {31'h0, in_ready}, 1);
   endtask

   // One evaluation: accept, time the response, backpressure with ignored in_valid noise, drain.
   task automatic run_txn(input logic [31:0] pat, input int hold);
      logic [31:0] want;
      int lat;
      want = pat ^ m_key;
      chk("idle_in_ready", {31'h0, in_ready}, 1);
      in_valid = 1'b1;
      in_data  = pat;
      @(negedge clk);
      in_valid = 1'b0;
      chk("core_in", core_in, pat);
      chk("settle_in_ready", {31'h0, in_ready}, 0);
      lat = 0;
      while (!out_valid && lat < ST + 4) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, ST);
      chk("out_data", out_data, want);
      repeat (hold) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         @(negedge clk);
         chk("hold_out_valid", {31'h0, out_valid}, 1);
         chk("hold_out_data", out_data, want);
         chk("hold_in_ready", {31'h0, in_ready}, 0);
         chk("hold_core_in", core_in, pat);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      m_cnt++;
      chk("drain_out_valid", {31'h0, out_valid}, 0);
      chk("eval_cnt", {16'h0, eval_cnt}, {16'h0, m_cnt});
      chk("drain_in_ready", {31'h0, in_ready}, 1);
   endtask

   initial begin
      logic [31:0] k;
      logic [31:0] pat;
      rst = 1'b1; key_valid = 1'b0; key_bit = 1'b0; key_clear = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      m_key = '0; m_cnt = '0;
      repeat (2) @(negedge clk);
      chk_reset_state("rst");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_state("post_rst");

      // Reference key with three random stalls
      send_key(32'hA5C3_0F96, KW, rand_gaps(3));
      check_keyed(32'hA5C3_0F96);

      // Reference evaluation with 10 cycles of backpressure
      run_txn(32'h0000_FFFF, 10);
      chk("ref_response", out_data, 32'hA5C3_F069);

      for (int i = 0; i < 6; i++) run_txn($urandom, $urandom_range(3, 0));

      // key_clear in HOLD beats a simultaneous out_ready
      pat = $urandom;
      in_valid = 1'b1; in_data = pat;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (ST) @(negedge clk);
      chk("hold_before_clear", {31'h0, out_valid}, 1);
      key_clear = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      key_clear = 1'b0; out_ready = 1'b0;
      m_key = '0;
      chk("clr_out_valid", {31'h0, out_valid}, 0);
      chk("clr_keyed", {31'h0, keyed}, 0);
      chk("clr_core_key", core_key, m_key);
      chk("clr_key_ready", {31'h0, key_ready}, 1);
      chk("clr_in_ready", {31'h0, in_ready}, 0);
      chk("clr_eval_cnt", {16'h0, eval_cnt}, {16'h0, m_cnt});
      chk("clr_core_in", core_in, pat);

      // Partial load, then clear with a bit presented in the same cycle
      send_key($urandom, 17, 0);
      chk("partial_keyed", {31'h0, keyed}, 0);
      key_clear = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
      @(negedge clk);
      key_clear = 1'b0; key_valid = 1'b0;
      chk("mid_clr_core_key", core_key, 0);
      chk("mid_clr_keyed", {31'h0, keyed}, 0);
      chk("mid_clr_key_ready", {31'h0, key_ready}, 1);
      k = $urandom;
      send_key(k, KW, rand_gaps(2));
      check_keyed(k);
      run_txn($urandom, 1);

      // Bits offered after commit are ignored
      key_valid = 1'b1; key_bit = ~k[0];
      repeat (3) @(negedge clk);
      key_valid = 1'b0;
      chk("rekey_ignored", core_key, m_key);

      // Completion counter wrap
      force dut.eval_cnt = 16'hFFFE;
      #1 release dut.eval_cnt;
      m_cnt = 16'hFFFE;
      run_txn($urandom, 0);
      run_txn($urandom, 2);
      chk("wrapped", {16'h0, eval_cnt}, 0);

      // Reset while settling
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_state("mid_settle_rst");
      rst = 1'b0;
      repeat (ST + 2) @(negedge clk);
      chk("no_spurious_valid", {31'h0, out_valid}, 0);
      chk("rst_keyed", {31'h0, keyed}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
